// File: rtl/waste_pile_server.sv
// waste_pile_server
// Waste pile of a solitaire engine. Cards are pushed onto the top of the pile
// by the draw logic. A mover can take the top card with an offer/accept/reject
// handshake. The whole pile can also be streamed bottom-first back to the talon.
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   push_valid/push_card/push_ready push handshake from the draw logic
//   take_req, take_accept/reject    take request and the destination's answer
//   offer_valid/offer_card          top card offered while a take is pending
//   take_done, take_empty           one-cycle result pulses for a take
//   recycle_req                     request to turn the pile over to the talon
//   rec_valid/rec_card/rec_last     card stream to the talon
//   rec_ready                       talon accepts rec_card
//   recycle_done                    one-cycle pulse when the recycle is complete
//   top_card, waste_size            current top card (0 if empty) and card count
module waste_pile_server #(
   parameter int CARD_SIZE  = 6,
   parameter int PILE_DEPTH = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push_valid,
   input  logic [CARD_SIZE-1:0] push_card,
   output logic                 push_ready,
   input  logic                 take_req,
   input  logic                 take_accept,
   input  logic                 take_reject,
   output logic                 offer_valid,
   output logic [CARD_SIZE-1:0] offer_card,
   output logic                 take_done,
   output logic                 take_empty,
   input  logic                 recycle_req,
   output logic                 rec_valid,
   output logic [CARD_SIZE-1:0] rec_card,
   output logic                 rec_last,
   input  logic                 rec_ready,
   output logic                 recycle_done,
   output logic [CARD_SIZE-1:0] top_card,
   output logic [4:0]           waste_size
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_OFFER   = 2'd1;
   localparam logic [1:0] S_RECYCLE = 2'd2;
   localparam logic [4:0] DEPTH5    = 5'(PILE_DEPTH);

   logic [PILE_DEPTH-1:0][CARD_SIZE-1:0] slot_q, slot_d;
   logic [1:0] state_q, state_d;
   logic [4:0] size_q, size_d;
   logic [4:0] idx_q, idx_d;
   logic       take_done_q, take_done_d;
   logic       take_empty_q, take_empty_d;
   logic       recycle_done_q, recycle_done_d;
   logic [4:0] top_idx;
   logic       push_ok;

   // Only meaningful when size_q > 0; every user below is guarded by that.
   assign top_idx = size_q - 5'd1;
   assign push_ok = (state_q == S_IDLE) && (size_q < DEPTH5) && !take_req && !recycle_req;

   always_comb begin
      slot_d         = slot_q;
      state_d        = state_q;
      size_d         = size_q;
      idx_d          = idx_q;
      take_done_d    = 1'b0;
      take_empty_d   = 1'b0;
      recycle_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            // take_req outranks recycle_req; a push only happens with neither pending.
            if (take_req) begin
               if (size_q == 5'd0) take_empty_d = 1'b1;
               else                state_d      = S_OFFER;
            end else if (recycle_req) begin
               if (size_q == 5'd0) begin
                  recycle_done_d = 1'b1;
               end else begin
                  state_d = S_RECYCLE;
                  idx_d   = 5'd0;
               end
            end else if (push_valid && push_ok) begin
               slot_d[size_q] = push_card;
               size_d         = size_q + 5'd1;
            end
         end
         S_OFFER: begin
            if (take_accept) begin
               slot_d[top_idx] = '0;
               size_d          = top_idx;
               state_d         = S_IDLE;
               take_done_d     = 1'b1;
            end else if (take_reject) begin
               state_d = S_IDLE;
            end
         end
         S_RECYCLE: begin
            if (rec_ready) begin
               if (idx_q == top_idx) begin
                  slot_d         = '0;
                  size_d         = 5'd0;
                  state_d        = S_IDLE;
                  recycle_done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q         <= '0;
         state_q        <= S_IDLE;
         size_q         <= 5'd0;
         idx_q          <= 5'd0;
         take_done_q    <= 1'b0;
         take_empty_q   <= 1'b0;
         recycle_done_q <= 1'b0;
      end else begin
         slot_q         <= slot_d;
         state_q        <= state_d;
         size_q         <= size_d;
         idx_q          <= idx_d;
         take_done_q    <= take_done_d;
         take_empty_q   <= take_empty_d;
         recycle_done_q <= recycle_done_d;
      end
   end

   // The state is already IDLE while rst is held, so push_ready is gated explicitly.
   assign push_ready   = push_ok && !rst;
   assign top_card     = (size_q == 5'd0) ? '0 : slot_q[top_idx];
   assign waste_size   = size_q;
   assign offer_valid  = (state_q == S_OFFER);
   assign offer_card   = offer_valid ? top_card : '0;
   assign rec_valid    = (state_q == S_RECYCLE);
   assign rec_card     = rec_valid ? slot_q[idx_q] : '0;
   assign rec_last     = rec_valid && (idx_q == top_idx);
   assign take_done    = take_done_q;
   assign take_empty   = take_empty_q;
   assign recycle_done = recycle_done_q;

endmodule

// File: tb/tb_waste_pile_server.sv
module tb_waste_pile_server;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push_valid = 0, take_req = 0, take_accept = 0, take_reject = 0;
   logic       recycle_req = 0, rec_ready = 0;
   logic [5:0] push_card = 0;
   logic       push_ready, offer_valid, take_done, take_empty;
   logic       rec_valid, rec_last, recycle_done;
   logic [5:0] offer_card, rec_card, top_card;
   logic [4:0] waste_size;

   waste_pile_server dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_card(push_card), .push_ready(push_ready),
      .take_req(take_req), .take_accept(take_accept), .take_reject(take_reject),
      .offer_valid(offer_valid), .offer_card(offer_card),
      .take_done(take_done), .take_empty(take_empty),
      .recycle_req(recycle_req), .rec_valid(rec_valid), .rec_card(rec_card),
      .rec_last(rec_last), .rec_ready(rec_ready), .recycle_done(recycle_done),
      .top_card(top_card), .waste_size(waste_size)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: the pile is a queue (index 0 = bottom), mode 0/1/2 =
   // waiting / offering top card / streaming to talon.
   int q[$];
   int mode = 0;
   int rec_i = 0;
   bit m_td = 0, m_te = 0, m_rd = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete(); mode = 0; rec_i = 0; m_td = 0; m_te = 0; m_rd = 0;
      end else begin
         m_td = 0; m_te = 0; m_rd = 0;
         case (mode)
            0: begin
               if (take_req) begin
                  if (q.size() == 0) m_te = 1; else mode = 1;
               end else if (recycle_req) begin
                  if (q.size() == 0) m_rd = 1; else begin mode = 2; rec_i = 0; end
               end else if (push_valid && q.size() < 24) begin
                  q.push_back(int'(push_card));
               end
            end
            1: begin
               if (take_accept) begin
                  void'(q.pop_back()); m_td = 1; mode = 0;
               end else if (take_reject) mode = 0;
            end
            default: begin
               if (rec_ready) begin
                  if (rec_i == q.size() - 1) begin q.delete(); m_rd = 1; mode = 0; end
                  else rec_i++;
               end
            end
         endcase
      end
   end

   // Cycle-by-cycle comparison on the falling edge.
   always @(negedge clk) begin
      int n, etop;
      n = q.size();
      etop = (n > 0) ? q[n-1] : 0;
      chk("push_ready", int'(push_ready),
          int'(!rst && mode == 0 && n < 24 && !take_req && !recycle_req));
      chk("waste_size", int'(waste_size), n);
      chk("top_card", int'(top_card), etop);
      chk("offer_valid", int'(offer_valid), int'(mode == 1));
      chk("offer_card", int'(offer_card), (mode == 1) ? etop : 0);
      chk("rec_valid", int'(rec_valid), int'(mode == 2));
      chk("rec_card", int'(rec_card), (mode == 2) ? q[rec_i] : 0);
      chk("rec_last", int'(rec_last), int'(mode == 2 && rec_i == n - 1));
      chk("take_done", int'(take_done), int'(m_td));
      chk("take_empty", int'(take_empty), int'(m_te));
      chk("recycle_done", int'(recycle_done), int'(m_rd));
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push(input int c);
      push_valid = 1; push_card = 6'(c); tick(); push_valid = 0;
   endtask

   task automatic take(input bit acc);
      take_req = 1; tick(); take_req = 0;
      if (acc) take_accept = 1; else take_reject = 1;
      tick(); take_accept = 0; take_reject = 0;
   endtask

   initial begin
      // Reset state
      tick(); tick();
      chk("rst_push_ready", int'(push_ready), 0);
      chk("rst_size", int'(waste_size), 0);
      rst = 0;
      #1 chk("post_rst_push_ready", int'(push_ready), 1);
      tick();

      // Push 5, 9, 12 then an accepted take
      push(5); push(9); push(12);
      chk("lit_size3", int'(waste_size), 3);
      chk("lit_top12", int'(top_card), 12);
      take_req = 1; tick(); take_req = 0;
      chk("lit_offer12", int'(offer_card), 12);
      take_accept = 1; tick(); take_accept = 0;
      chk("lit_take_done", int'(take_done), 1);
      chk("lit_size2", int'(waste_size), 2);
      chk("lit_top9", int'(top_card), 9);
      tick();
      chk("lit_take_done_pulse", int'(take_done), 0);

      // Reject leaves the pile alone, then accept removes the top
      take(0);
      chk("lit_rej_size", int'(waste_size), 2);
      chk("lit_rej_done", int'(take_done), 0);
      take(1);
      chk("lit_acc_top", int'(top_card), 5);

      // Recycle 5, 9, 12 with rec_ready held low for two cycles
      push(9); push(12);
      recycle_req = 1; tick(); recycle_req = 0;
      chk("lit_rec0", int'(rec_card), 5);
      tick(); tick();
      chk("lit_rec0_hold", int'(rec_card), 5);
      chk("lit_rec0_last", int'(rec_last), 0);
      rec_ready = 1; tick();
      chk("lit_rec1", int'(rec_card), 9);
      tick();
      chk("lit_rec2", int'(rec_card), 12);
      chk("lit_rec2_last", int'(rec_last), 1);
      tick(); rec_ready = 0;
      chk("lit_rec_done", int'(recycle_done), 1);
      chk("lit_rec_size", int'(waste_size), 0);

      // Take and recycle on an empty pile
      take_req = 1; tick(); take_req = 0;
      chk("lit_take_empty", int'(take_empty), 1);
      tick();
      chk("lit_take_empty_once", int'(take_empty), 0);
      recycle_req = 1; tick(); recycle_req = 0;
      chk("lit_rec_empty_done", int'(recycle_done), 1);
      tick();

      // Fill to 24, stalled push completes after the take returns to idle
      for (int i = 1; i <= 24; i++) push(i);
      push_valid = 1; push_card = 6'd50;
      chk("lit_full_ready", int'(push_ready), 0);
      tick(); tick();
      chk("lit_full_size", int'(waste_size), 24);
      take_req = 1; tick(); take_req = 0;
      take_accept = 1; tick(); take_accept = 0;
      chk("lit_after_take_size", int'(waste_size), 23);
      chk("lit_after_take_ready", int'(push_ready), 1);
      tick(); push_valid = 0;
      chk("lit_held_push_size", int'(waste_size), 24);
      chk("lit_held_push_top", int'(top_card), 50);

      // Reset mid-recycle after one card
      recycle_req = 1; tick(); recycle_req = 0;
      rec_ready = 1; tick(); rec_ready = 0;
      chk("lit_mid_rec", int'(rec_card), 2);
      #2 rst = 1;
      #1;
      chk("lit_arst_rec_valid", int'(rec_valid), 0);
      chk("lit_arst_rec_card", int'(rec_card), 0);
      chk("lit_arst_size", int'(waste_size), 0);
      chk("lit_arst_top", int'(top_card), 0);
      chk("lit_arst_ready", int'(push_ready), 0);
      tick(); rst = 0;
      tick();
      chk("lit_arst_no_done", int'(recycle_done), 0);
      tick();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         push_valid  = ($urandom_range(0, 1) == 1);
         push_card   = 6'($urandom_range(1, 63));
         take_req    = ($urandom_range(0, 4) == 0);
         take_accept = ($urandom_range(0, 2) == 0);
         take_reject = ($urandom_range(0, 2) == 0);
         recycle_req = ($urandom_range(0, 15) == 0);
         rec_ready   = ($urandom_range(0, 1) == 1);
         rst         = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 0;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
